l2_cache: RTL and testbench



---
 rtl/l2_pkg.sv | 17 +
 rtl/l2_line_array.sv | 49 ++++
 rtl/l2_cache.sv | 187 ++++++++++++++++++
 tb/tb_l2_cache.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared types and widths for the direct-mapped write-back L2 cache.
// State encoding plus line and address widths live here.
package l2_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 30;
  localparam int BLK_W  = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_RESPOND
  } state_t;

endpackage

// File: rtl/l2_line_array.sv
// Tag/valid/dirty/data storage for the L2 cache.
// One write port, combinational read at the same index.
module l2_line_array
  import l2_pkg::*;
#(
  parameter  int SETS = 64,
  localparam int IDXW = $clog2(SETS),
  localparam int TAGW = BLK_W - IDXW
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [IDXW-1:0]   i_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAGW-1:0]   o_tag,
  output logic [LINE_W-1:0] o_data,
  input  logic              i_we,
  input  logic              i_wdirty,
  input  logic [TAGW-1:0]   i_wtag,
  input  logic [LINE_W-1:0] i_wdata
);

  logic              r_valid [SETS];
  logic              r_dirty [SETS];
  logic [TAGW-1:0]   r_tag   [SETS];
  logic [LINE_W-1:0] r_data  [SETS];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < SETS; i++) begin
        r_valid[i] <= 1'b0;
        r_dirty[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_wdirty;
      r_tag[i_idx]   <= i_wtag;
      r_data[i_idx]  <= i_wdata;
    end
  end

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back write-allocate L2 cache between L1 and memory.
// Define L2_STAT_EN to keep access/miss counters and print on each miss.
module l2_cache
  import l2_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic [LINE_W-1:0] l1_wdata,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_ready,
  output logic              l1_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BLK_W-1:0]  mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = BLK_W - IDXW;

  state_t r_state, w_next;

  logic [BLK_W-1:0]  r_blk;
  logic              r_wr;
  logic [LINE_W-1:0] r_wdata;

  logic [LINE_W-1:0] r_l1_rdata;
  logic              r_l1_ready;
  logic              r_l1_stall;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [BLK_W-1:0]  r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  logic [IDXW-1:0]   w_idx;
  logic [TAGW-1:0]   w_tag;
  logic              w_valid;
  logic              w_dirty;
  logic [TAGW-1:0]   w_vtag;
  logic [LINE_W-1:0] w_vdata;
  logic              w_hit;
  logic              w_accept;
  logic              w_we;
  logic              w_wdirty;
  logic [LINE_W-1:0] w_wline;
  logic              w_unused_lsb;

  assign w_idx        = r_blk[IDXW-1:0];
  assign w_tag        = r_blk[BLK_W-1:IDXW];
  assign w_hit        = w_valid && (w_vtag == w_tag);
  // The request is still held high during the l1_ready cycle.
  assign w_accept     = (l1_read || l1_write) && !r_l1_ready;
  assign w_unused_lsb = ^l1_addr[1:0];

  l2_line_array #(.SETS(SETS)) u_lines (
    .clk      (clk),
    .i_rst    (proc_reset),
    .i_idx    (w_idx),
    .o_valid  (w_valid),
    .o_dirty  (w_dirty),
    .o_tag    (w_vtag),
    .o_data   (w_vdata),
    .i_we     (w_we),
    .i_wdirty (w_wdirty),
    .i_wtag   (w_tag),
    .i_wdata  (w_wline)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_we     = 1'b0;
    w_wdirty = 1'b1;
    w_wline  = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_next = S_RESPOND;
          w_we   = r_wr;
        end else if (w_valid && w_dirty) begin
          w_next = S_WRITEBACK;
        end else if (r_wr) begin
          w_next = S_RESPOND;
          w_we   = 1'b1;
        end else begin
          w_next = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          if (r_wr) begin
            w_next = S_RESPOND;
            w_we   = 1'b1;
          end else begin
            w_next = S_ALLOCATE;
          end
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          w_next   = S_RESPOND;
          w_we     = 1'b1;
          w_wdirty = 1'b0;
          w_wline  = mem_rdata;
        end
      end
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_blk       <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_l1_rdata  <= '0;
      r_l1_ready  <= 1'b0;
      r_l1_stall  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_l1_ready  <= (r_state == S_RESPOND);
      r_l1_stall  <= (w_next == S_WRITEBACK) || (w_next == S_ALLOCATE);
      r_mem_read  <= (w_next == S_ALLOCATE);
      r_mem_write <= (w_next == S_WRITEBACK);
      if (r_state == S_IDLE && w_accept) begin
        r_blk   <= l1_addr[ADDR_W-1:2];
        r_wr    <= l1_write;
        r_wdata <= l1_wdata;
      end
      if (r_state == S_COMPARE && w_next == S_WRITEBACK) begin
        r_mem_addr  <= {w_vtag, w_idx};
        r_mem_wdata <= w_vdata;
      end
      if (w_next == S_ALLOCATE && r_state != S_ALLOCATE)
        r_mem_addr <= r_blk;
      if (r_state == S_COMPARE && w_hit && !r_wr)
        r_l1_rdata <= w_vdata;
      if (r_state == S_ALLOCATE && mem_ready)
        r_l1_rdata <= mem_rdata;
    end
  end

  assign l1_rdata  = r_l1_rdata;
  assign l1_ready  = r_l1_ready;
  assign l1_stall  = r_l1_stall;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef L2_STAT_EN
  logic [15:0] r_acc;
  logic [15:0] r_miss;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_acc  <= '0;
      r_miss <= '0;
    end else if (r_state == S_COMPARE) begin
      r_acc <= r_acc + 16'd1;
      if (!w_hit) begin
        r_miss <= r_miss + 16'd1;
        $display("L2 : Miss/Total = %0d/%0d", r_miss + 16'd1, r_acc + 16'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Randomized bench for l2_cache against a set-array/memory-map model,
// acting as both the L1 requester and the backing memory.
module tb_l2_cache;

  localparam int SETS = 64;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         l1_read, l1_write;
  logic [29:0]  l1_addr;
  logic [127:0] l1_wdata, l1_rdata;
  logic         l1_ready, l1_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  l2_cache #(.SETS(SETS)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .l1_read    (l1_read),
    .l1_write   (l1_write),
    .l1_addr    (l1_addr),
    .l1_wdata   (l1_wdata),
    .l1_rdata   (l1_rdata),
    .l1_ready   (l1_ready),
    .l1_stall   (l1_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  bit           mv   [SETS];
  bit           md   [SETS];
  logic [27:0]  mt   [SETS];
  logic [127:0] mdat [SETS];
  logic [127:0] mem  [logic [27:0]];
  logic [127:0] last_rd;

  logic [27:0]  obs_wb_addr, obs_rd_addr;
  logic [127:0] obs_wb_data;
  int           obs_cyc, obs_traffic;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_get(input logic [27:0] b);
    if (!mem.exists(b))
      mem[b] = {$urandom, $urandom, $urandom, $urandom};
    return mem[b];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) begin
      mv[i] = 0; md[i] = 0; mt[i] = '0; mdat[i] = '0;
    end
    last_rd = '0;
  endtask

  // Exclusivity and stall tracking every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mem_excl", 128'(mem_read && mem_write), 128'd0);
      chk("stall_track", 128'(l1_stall), 128'(mem_read || mem_write));
    end
  end

  task automatic run_req(input bit rd, input bit wr,
                         input logic [29:0] a, input logic [127:0] wd);
    logic [27:0]  blk, tg, wb_addr;
    logic [127:0] wb_data, exp_rd, fill;
    int           idx, dly, cyc;
    bit           hit, wb, fetch, done;
    bit           seen_wr, seen_rd, done_wr, done_rd;
    blk     = a[29:2];
    idx     = int'(blk % SETS);
    tg      = blk / SETS;
    hit     = mv[idx] && (mt[idx] == tg);
    wb      = !hit && mv[idx] && md[idx];
    fetch   = !hit && !wr;
    wb_addr = mt[idx] * 28'(SETS) + 28'(idx);
    wb_data = mdat[idx];
    fill    = fetch ? mem_get(blk) : '0;
    exp_rd  = wr ? last_rd : (hit ? mdat[idx] : fill);
    seen_wr = 0; seen_rd = 0; done_wr = 0; done_rd = 0;
    done = 0; dly = 0; cyc = 0; obs_traffic = 0;
    @(negedge clk);
    l1_read = rd; l1_write = wr; l1_addr = a; l1_wdata = wd;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_write) begin
        if (done_wr) chk("wr_drop", 128'd1, 128'd0);
        else begin
          if (!seen_wr) begin
            seen_wr = 1; obs_traffic++;
            chk("wb_expected", 128'd1, 128'(wb));
            chk("wb_addr", 128'(mem_addr), 128'(wb_addr));
            chk("wb_data", mem_wdata, wb_data);
            obs_wb_addr = mem_addr; obs_wb_data = mem_wdata;
            dly = $urandom_range(0, 3);
          end
          if (dly == 0) begin mem_ready = 1'b1; done_wr = 1; end
          else dly--;
        end
      end
      if (mem_read) begin
        if (done_rd) chk("rd_drop", 128'd1, 128'd0);
        else begin
          if (!seen_rd) begin
            seen_rd = 1; obs_traffic++;
            chk("fetch_expected", 128'd1, 128'(fetch));
            chk("rd_after_wb", 128'(done_wr), 128'(wb));
            chk("rd_addr", 128'(mem_addr), 128'(blk));
            obs_rd_addr = mem_addr;
            mem_rdata = fill;
            dly = $urandom_range(0, 3);
          end
          if (dly == 0) begin mem_ready = 1'b1; done_rd = 1; end
          else dly--;
        end
      end
      if (l1_ready) begin done = 1; cyc = c; end
    end
    obs_cyc = cyc;
    if (!done) chk("ready_timeout", 128'd0, 128'd1);
    else begin
      chk("wb_seen", 128'(seen_wr), 128'(wb));
      chk("rd_seen", 128'(seen_rd), 128'(fetch));
      if (hit || (!wb && wr)) chk("latency", 128'(cyc), 128'd3);
      chk("rdata", l1_rdata, exp_rd);
    end
    l1_read = 0; l1_write = 0;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("ready_pulse", 128'(l1_ready), 128'd0);
    chk("mem_idle", 128'(mem_read || mem_write), 128'd0);
    if (wb) mem[wb_addr] = wb_data;
    if (wr) begin
      mv[idx] = 1; md[idx] = 1; mt[idx] = tg; mdat[idx] = wd;
    end else begin
      if (!hit) begin
        mv[idx] = 1; md[idx] = 0; mt[idx] = tg; mdat[idx] = fill;
      end
      last_rd = exp_rd;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] va, vb, vc, vd;
    bit           got;
    logic [29:0]  ra;
    int           op;
    va = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    vb = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    vc = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    vd = 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004;
    proc_reset = 1; l1_read = 0; l1_write = 0; l1_addr = '0;
    l1_wdata = '0; mem_rdata = '0; mem_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_outs", {l1_ready, l1_stall, mem_read, mem_write}, 128'd0);
    chk("rst_addr", 128'(mem_addr), 128'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    chk("rst_rdata", l1_rdata, 128'd0);
    proc_reset = 0;
    mon_en = 1;

    mem[28'h4] = va;
    run_req(1, 0, 30'h10, '0);
    chk("cold_rd_addr", 128'(obs_rd_addr), 128'h4);
    chk("cold_rdata", l1_rdata, va);
    run_req(1, 0, 30'h10, '0);
    chk("hit_cyc", 128'(obs_cyc), 128'd3);
    chk("hit_notraffic", 128'(obs_traffic), 128'd0);
    chk("hit_rdata", l1_rdata, va);

    run_req(0, 1, 30'h10, vb);
    run_req(1, 0, 30'h110, '0);
    chk("evict_wb_addr", 128'(obs_wb_addr), 128'h4);
    chk("evict_wb_data", obs_wb_data, vb);
    chk("evict_rd_addr", 128'(obs_rd_addr), 128'h44);

    run_req(0, 1, 30'h14, vc);
    chk("wmiss_cyc", 128'(obs_cyc), 128'd3);
    chk("wmiss_notraffic", 128'(obs_traffic), 128'd0);
    run_req(1, 0, 30'h114, '0);
    chk("wmiss_dirty_addr", 128'(obs_wb_addr), 128'h5);
    chk("wmiss_dirty_data", obs_wb_data, vc);

    run_req(1, 1, 30'h18, vd);
    run_req(1, 0, 30'h18, '0);
    chk("both_is_write", l1_rdata, vd);

    @(negedge clk);
    l1_read = 1; l1_addr = 30'h1C;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mem_read) got = 1;
    end
    chk("alloc_reached", 128'(got), 128'd1);
    proc_reset = 1; l1_read = 0;
    @(negedge clk);
    chk("abort_outs", {l1_ready, l1_stall, mem_read, mem_write}, 128'd0);
    chk("abort_addr", 128'(mem_addr), 128'd0);
    chk("abort_rdata", l1_rdata, 128'd0);
    proc_reset = 0;
    model_clear();
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("stray_ignored", {l1_ready, mem_read, mem_write}, 128'd0);
    run_req(1, 0, 30'h1C, '0);
    chk("reread_miss", 128'(obs_rd_addr), 128'h7);

    for (int n = 0; n < 400; n++) begin
      ra = {28'($urandom_range(0, 3) * SETS + $urandom_range(0, 7)),
            2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        mem_ready = 1;
      end
      run_req(op != 1, op != 0, ra,
              {$urandom, $urandom, $urandom, $urandom});
    end

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
